stoch_to_bin: RTL
=================

# stoch_to_bin

Stochastic-to-binary converter that sits directly downstream of the SNG stage. It consumes the serial stochastic bit stream on `i_sn_bit`, counts ones over a fixed window of `STREAM_LEN` clock cycles, and returns a saturated binary value in the same encoding the SNG accepts on its binary input. It closes the loop binary → stochastic → binary, and is used after stochastic arithmetic stages to recover results.

## Interface
- `WIDTH`, default 4: binary result width. Matches the SNG binary input width.
- `STREAM_LEN`, default 16: window length in bits. Legal range is 2 ≤ `STREAM_LEN` ≤ 2**`WIDTH`.
- `i_clk_s2b`, input, 1: clock. All logic is on the rising edge.
- `i_rst_s2b`, input, 1: reset, synchronous, active-high.
- `i_start_s2b`, input, 1: begin a conversion window. Level-sampled.
- `i_stop_s2b`, input, 1: abort the current window.
- `i_sn_bit`, input, 1: stochastic bit stream from the SNG.
- `o_x_bn`, output, `WIDTH` (`WIDTH`+1 with `S2B_BIPOLAR_EN`): converted value. Held until the next completed window.
- `o_valid_s2b`, output, 1: one-cycle pulse when `o_x_bn` updates.
- `o_busy_s2b`, output, 1: high while in COUNT.

## Operation
- There are two states: IDLE and COUNT. Internal registers:
  - bit counter `bcnt`, width `$clog2(STREAM_LEN+1)`
  - ones counter `ones`, same width
- **IDLE**:
  - `i_start_s2b`=1 at an edge → COUNT; `bcnt`=0 and `ones`=0.
  - `i_stop_s2b` and `i_sn_bit` are ignored.
- **COUNT**, at each edge:
  - `ones` += `i_sn_bit`.
  - `bcnt` += 1.
  - On the edge where `bcnt` reaches `STREAM_LEN`, i.e. the final bit is sampled:
    - `o_x_bn` ← result of the final count.
    - `o_valid_s2b` ← 1 for one cycle.
    - Next state is IDLE, or COUNT with counters cleared if `i_start_s2b`=1 on that same edge (back-to-back windows with no gap).
- **Unipolar result** (default): `o_x_bn` = min(`ones`, 2**`WIDTH`−1).
  - The all-ones window with `STREAM_LEN`=2**`WIDTH` gives 16 for the default parameters; this saturates to 15.
- **Stop** in COUNT:
  - Returns to IDLE at that edge with no valid pulse.
  - `o_x_bn` keeps its previous value.
  - The bit present on that edge is discarded.
  - Stop wins over completion when both fall on the final edge.
  - Stop wins over start when both are high on the same edge.
- `i_start_s2b` during COUNT, except on the final edge, is ignored. It does not restart the window.
- **Reset** (any state, including mid-window):
  - State → IDLE; `bcnt`=`ones`=0.
  - `o_x_bn`=0, `o_valid_s2b`=0, `o_busy_s2b`=0 after the reset edge.
- **Width rule**: `ones` never exceeds `STREAM_LEN`, so it cannot overflow. Saturation applies only at output truncation.

## Timing
- Start sampled at edge t.
- Stream bits are sampled at edges t+1 … t+`STREAM_LEN`. This matches an SNG whose first bit appears the cycle after its own start.
- `o_x_bn` and `o_valid_s2b` update at edge t+`STREAM_LEN`. The valid pulse drops at t+`STREAM_LEN`+1 unless another window completes there, which is impossible for `STREAM_LEN`≥2.
- `o_busy_s2b` is 1 from edge t through edge t+`STREAM_LEN`−1. It stays 1 across a back-to-back restart.
- Latency from start to valid is `STREAM_LEN` cycles. Sustained throughput is one result per `STREAM_LEN` cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `S2B_BIPOLAR_EN`:
  - **Defined**: bipolar decoding. `o_x_bn` is `WIDTH`+1 bits two's complement, = 2·`ones` − `STREAM_LEN`, saturated to [−2**`WIDTH`, 2**`WIDTH`−1]. Default range is −16 … +15; the all-ones window gives +16, which saturates to +15.
  - **Not defined**: unipolar decoding as described above, with `o_x_bn` `WIDTH` bits.
  - Control, timing and reset behaviour are identical in both builds.

## Test plan
- **Reset and idle.** Reset 2 cycles, then idle 5 cycles → `o_x_bn`=0, `o_valid_s2b`=0, `o_busy_s2b`=0 throughout.
- **Basic conversion.** Start, then 16 bits with 5 ones (pattern 0x8421 plus one extra 1) → valid pulse exactly 16 cycles after start, `o_x_bn`=5. With `S2B_BIPOLAR_EN`, `o_x_bn`=−6.
- **Saturation.** Start with all-ones stream → `o_x_bn`=15 (unipolar) or +15 (bipolar). All-zeros stream → 0 (unipolar) or −16 (bipolar).
- **Abort.** Start, 7 bits, then stop=1 → no valid pulse, `o_busy_s2b`=0 next cycle, `o_x_bn` unchanged. Stop and start together in COUNT → IDLE.
- **Back-to-back.** Start held high on the final edge of window 1 (value 9) → window 2 begins with no gap. Valid pulses are exactly 16 cycles apart; window 2 with 3 ones gives `o_x_bn`=3.
- **Reset mid-window and SNG loopback.**
  - Reset at bit 10 → outputs 0, no valid; a fresh window converts correctly.
  - Loopback from the SNG for x=0…15 → each result is within the SNG's quantisation error of x.

Source files
------------

// File: rtl/stoch_to_bin_if.sv
// Stream/result bundle between an SNG-side driver and stoch_to_bin.
// Result width follows the S2B_BIPOLAR_EN build option (WIDTH+1 when defined).
interface stoch_to_bin_if #(
    parameter int WIDTH = 4
);
`ifdef S2B_BIPOLAR_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif

    logic          i_start_s2b;
    logic          i_stop_s2b;
    logic          i_sn_bit;
    logic [XW-1:0] o_x_bn;
    logic          o_valid_s2b;
    logic          o_busy_s2b;

    modport master (
        output i_start_s2b, i_stop_s2b, i_sn_bit,
        input  o_x_bn, o_valid_s2b, o_busy_s2b
    );

    modport slave (
        input  i_start_s2b, i_stop_s2b, i_sn_bit,
        output o_x_bn, o_valid_s2b, o_busy_s2b
    );
endinterface

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over a STREAM_LEN-bit window and
// returns a saturated binary value. Define S2B_BIPOLAR_EN for two's-complement bipolar decoding.
module stoch_to_bin #(
    parameter int WIDTH      = 4,
    parameter int STREAM_LEN = 16
) (
    input  logic          i_clk_s2b,
    input  logic          i_rst_s2b,
    stoch_to_bin_if.slave s2b
);
`ifdef S2B_BIPOLAR_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif
    localparam int CW = $clog2(STREAM_LEN + 1);
    localparam int EW = CW + WIDTH + 2;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bcnt_q, ones_q;
    logic [CW-1:0] ones_fin;
    logic [XW-1:0] x_q, x_fin;
    logic          valid_q;
    logic          last_bit, clear, advance, load;

`ifdef S2B_BIPOLAR_EN
    logic signed [EW-1:0] bip;
`else
    logic [EW-1:0] uext;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        ones_fin = ones_q + CW'(s2b.i_sn_bit);
        last_bit = (bcnt_q == CW'(STREAM_LEN - 1));

        case (state_q)
            IDLE: begin
                if (s2b.i_start_s2b) begin
                    state_d = COUNT;
                    clear   = 1'b1;
                end
            end
            COUNT: begin
                // Abort beats both completion and a same-edge restart.
                if (s2b.i_stop_s2b) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    load = 1'b1;
                    if (s2b.i_start_s2b) clear = 1'b1;
                    else                 state_d = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result of the window including the bit sampled on the final edge.
    always_comb begin
`ifdef S2B_BIPOLAR_EN
        bip = $signed(EW'({ones_fin, 1'b0})) - $signed(EW'(STREAM_LEN));
        if (bip > $signed(EW'(2**WIDTH - 1)))
            x_fin = XW'(2**WIDTH - 1);
        else if (bip < -$signed(EW'(2**WIDTH)))
            x_fin = XW'(-(2**WIDTH));
        else
            x_fin = bip[XW-1:0];
`else
        uext = EW'(ones_fin);
        if (uext > EW'(2**WIDTH - 1))
            x_fin = XW'(2**WIDTH - 1);
        else
            x_fin = uext[XW-1:0];
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_s2b) begin
        if (i_rst_s2b) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            ones_q  <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= load;
            if (load) x_q <= x_fin;
            if (clear) begin
                bcnt_q <= '0;
                ones_q <= '0;
            end else if (advance) begin
                bcnt_q <= bcnt_q + 1'b1;
                ones_q <= ones_fin;
            end
        end
    end

    assign s2b.o_x_bn      = x_q;
    assign s2b.o_valid_s2b = valid_q;
    assign s2b.o_busy_s2b  = (state_q == COUNT);
endmodule
